tl_pkt_ingress: RTL and testbench

// Parametrised transport-layer ingress. Converts AXI-stream packets into HDR/BODY/TAIL flits for NUM_VC

---
 rtl/tl_pkt_ingress.sv | 194 +++++++++++++++++++
 tb/tb_tl_pkt_ingress.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_pkt_ingress.sv
`default_nettype none
// ============================================================================
// Module      : tl_pkt_ingress
// Description : AXI-stream to HDR/BODY/TAIL flit ingress with per-VC credit
//               tracking, wormhole VC locking and max-credit / RR allocation.
// Revision    : 1.0 - initial release
// ============================================================================
module tl_pkt_ingress #(
    parameter int AXI_D_WIDTH = 24,
    parameter int DEST_BITS   = 4,
    parameter int TYPE_BITS   = 2,
    parameter int NUM_VC      = 12,
    parameter int BUF_DEPTH   = 12,
    parameter int ALLOC_MODE  = 0,
    localparam int VC_W       = $clog2(NUM_VC),
    localparam int CR_W       = $clog2(BUF_DEPTH + 1),
    localparam int FLIT_W     = TYPE_BITS + AXI_D_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AXI_D_WIDTH-1:0] in_tdata,
    input  logic                   in_tvalid,
    input  logic                   in_tlast,
    input  logic [DEST_BITS-1:0]   in_tuser,
    output logic                   in_tready,
    output logic [FLIT_W-1:0]      flit_data,
    output logic [VC_W-1:0]        flit_vc,
    output logic                   flit_valid,
    input  logic                   flit_ready,
    input  logic                   cred_ret_valid,
    input  logic [VC_W-1:0]        cred_ret_vc,
    output logic [NUM_VC*CR_W-1:0] vc_credits,
    output logic                   busy,
    output logic                   err_cred_ovf
);

    localparam logic [TYPE_BITS-1:0] c_type_hdr  = TYPE_BITS'(2'b11);
    localparam logic [TYPE_BITS-1:0] c_type_body = TYPE_BITS'(2'b10);
    localparam logic [TYPE_BITS-1:0] c_type_tail = TYPE_BITS'(2'b01);
    localparam logic [CR_W-1:0]      c_full      = CR_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2
    } state_t;

    state_t                 r_state;
    logic [VC_W-1:0]        r_cur_vc;
    logic [DEST_BITS-1:0]   r_dest;
    logic [VC_W-1:0]        r_rr_ptr;
    logic [FLIT_W-1:0]      r_flit_data;
    logic [VC_W-1:0]        r_flit_vc;
    logic                   r_flit_valid;
    logic                   r_err;

    logic [CR_W-1:0]        w_cred [NUM_VC];
    logic [NUM_VC-1:0]      w_ovf;
    logic                   w_free;
    logic                   w_cur_cred_ok;
    logic                   w_load_hdr;
    logic                   w_load_body;
    logic                   w_load;
    logic [VC_W-1:0]        w_max_vc;
    logic [CR_W-1:0]        w_max_cred;
    logic                   w_any_cred;
    logic [VC_W-1:0]        w_rr_vc;
    logic                   w_rr_found;
    logic [VC_W-1:0]        w_pick_vc;
    logic [VC_W-1:0]        w_pick_next;

    assign w_free        = !r_flit_valid || flit_ready;
    assign w_cur_cred_ok = (w_cred[r_cur_vc] != '0);
    assign w_load_hdr    = (r_state == S_HDR) && w_free && w_cur_cred_ok;
    assign in_tready     = (r_state == S_BODY) && w_free && w_cur_cred_ok;
    assign w_load_body   = in_tvalid && in_tready;
    assign w_load        = w_load_hdr || w_load_body;

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        w_max_vc   = '0;
        w_max_cred = w_cred[0];
        w_any_cred = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_cred[v] != '0)
                w_any_cred = 1'b1;
            if (w_cred[v] > w_max_cred) begin
                w_max_cred = w_cred[v];
                w_max_vc   = VC_W'(v);
            end
        end
    end

    always_comb begin
        int idx;
        idx        = 0;
        w_rr_vc    = r_rr_ptr;
        w_rr_found = 1'b0;
        for (int k = 0; k < NUM_VC; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_VC)
                idx = idx - NUM_VC;
            if (!w_rr_found && (w_cred[VC_W'(idx)] != '0)) begin
                w_rr_found = 1'b1;
                w_rr_vc    = VC_W'(idx);
            end
        end
    end

    assign w_pick_vc   = (ALLOC_MODE == 1) ? w_rr_vc : w_max_vc;
    assign w_pick_next = (w_pick_vc == VC_W'(NUM_VC - 1)) ? '0 : w_pick_vc + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cur_vc     <= '0;
            r_dest       <= '0;
            r_rr_ptr     <= '0;
            r_flit_data  <= '0;
            r_flit_vc    <= '0;
            r_flit_valid <= 1'b0;
        end else begin
            if (w_load) begin
                r_flit_valid <= 1'b1;
                r_flit_vc    <= r_cur_vc;
                if (w_load_hdr)
                    r_flit_data <= {c_type_hdr, AXI_D_WIDTH'(r_dest)};
                else
                    r_flit_data <= {(in_tlast ? c_type_tail : c_type_body), in_tdata};
            end else if (flit_ready) begin
                r_flit_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (in_tvalid && w_any_cred) begin
                        r_cur_vc <= w_pick_vc;
                        r_dest   <= in_tuser;
                        if (ALLOC_MODE == 1)
                            r_rr_ptr <= w_pick_next;
                        r_state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_load_hdr)
                        r_state <= S_BODY;
                end
                S_BODY: begin
                    if (w_load_body && in_tlast)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A load and a return on the same VC in one cycle cancel out.
    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [CR_W-1:0] r_cnt;
        logic            w_dec;
        logic            w_inc;

        assign w_dec    = w_load && (r_cur_vc == VC_W'(v));
        assign w_inc    = cred_ret_valid && (cred_ret_vc == VC_W'(v));
        assign w_ovf[v] = w_inc && !w_dec && (r_cnt == c_full);

        always_ff @(posedge clk) begin
            if (rst)
                r_cnt <= c_full;
            else if (w_inc && !w_dec && (r_cnt != c_full))
                r_cnt <= r_cnt + 1'b1;
            else if (w_dec && !w_inc)
                r_cnt <= r_cnt - 1'b1;
        end

        assign w_cred[v]                   = r_cnt;
        assign vc_credits[v*CR_W +: CR_W]  = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (|w_ovf)
            r_err <= 1'b1;
    end

    assign flit_data    = r_flit_data;
    assign flit_vc      = r_flit_vc;
    assign flit_valid   = r_flit_valid;
    assign busy         = (r_state != S_IDLE) || r_flit_valid;
    assign err_cred_ovf = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tl_pkt_ingress.sv
`default_nettype none
// ============================================================================
// Module      : tb_tl_pkt_ingress
// Description : Scoreboard bench for tl_pkt_ingress; dut0 uses max-credit
//               allocation, dut1 round-robin allocation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tl_pkt_ingress;

    typedef struct packed {
        logic [3:0]  vc;
        logic [25:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] tdata  [2];
    logic        tvalid [2];
    logic        tlast  [2];
    logic [3:0]  tuser  [2];
    logic        tready [2];
    logic [25:0] fdata  [2];
    logic [3:0]  fvc    [2];
    logic        fvalid [2];
    logic        fready [2];
    logic        crv    [2];
    logic [3:0]  crvc   [2];
    logic [47:0] vcc    [2];
    logic        busy   [2];
    logic        err    [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   acc0    = 0;
    bit   done    = 0;

    always #5 clk = ~clk;

    tl_pkt_ingress #(.ALLOC_MODE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_tdata(tdata[0]), .in_tvalid(tvalid[0]), .in_tlast(tlast[0]), .in_tuser(tuser[0]),
        .in_tready(tready[0]),
        .flit_data(fdata[0]), .flit_vc(fvc[0]), .flit_valid(fvalid[0]), .flit_ready(fready[0]),
        .cred_ret_valid(crv[0]), .cred_ret_vc(crvc[0]),
        .vc_credits(vcc[0]), .busy(busy[0]), .err_cred_ovf(err[0])
    );

    tl_pkt_ingress #(.ALLOC_MODE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_tdata(tdata[1]), .in_tvalid(tvalid[1]), .in_tlast(tlast[1]), .in_tuser(tuser[1]),
        .in_tready(tready[1]),
        .flit_data(fdata[1]), .flit_vc(fvc[1]), .flit_valid(fvalid[1]), .flit_ready(fready[1]),
        .cred_ret_valid(crv[1]), .cred_ret_vc(crvc[1]),
        .vc_credits(vcc[1]), .busy(busy[1]), .err_cred_ovf(err[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic timeout(input string nm);
        n_total++;
        $display("FAIL %s: timed out waiting, expected event", nm);
    endtask

    function automatic logic [3:0] cred(input int d, input int v);
        return vcc[d][v*4 +: 4];
    endfunction

    task automatic push(input int d, input logic [3:0] vc, input logic [25:0] data);
        exp_t e;
        e.vc   = vc;
        e.data = data;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon_pop(input int d);
        exp_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_total++;
            $display("FAIL flit%0d_unexpected: got vc %0d data %0h, expected no flit", d, fvc[d], fdata[d]);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("flit%0d", d), {34'd0, fvc[d], fdata[d]}, {34'd0, e.vc, e.data});
    endtask

    // Scoreboard monitor: one comparison per flit handed downstream.
    always @(negedge clk) begin
        if (!rst) begin
            if (fvalid[0] && fready[0]) mon_pop(0);
            if (fvalid[1] && fready[1]) mon_pop(1);
        end
    end

    always @(negedge clk)
        if (!rst && tvalid[0] && tready[0]) acc0++;

    // Expected flits are queued up front; beats are then offered one by one.
    task automatic send_pkt(input int d, input logic [3:0] dest, input int nbeats,
                            input logic [23:0] base, input logic [3:0] exp_vc);
        push(d, exp_vc, {2'b11, 20'd0, dest});
        for (int i = 0; i < nbeats; i++)
            push(d, exp_vc, {(i == nbeats - 1) ? 2'b01 : 2'b10, base + 24'(i)});
        for (int i = 0; i < nbeats; i++) begin
            bit ok;
            ok       = 0;
            tdata[d] = base + 24'(i);
            tlast[d] = (i == nbeats - 1);
            tuser[d] = dest;
            tvalid[d] = 1'b1;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                if (tready[d]) ok = 1;
            end
            if (!ok) begin
                timeout($sformatf("beat_accept_dut%0d", d));
                tvalid[d] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        tvalid[d] = 1'b0;
        tlast[d]  = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (!busy[d]) return;
        end
        timeout($sformatf("idle_dut%0d", d));
    endtask

    task automatic reset_duts();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit ok;
        for (int d = 0; d < 2; d++) begin
            tdata[d] = '0; tvalid[d] = 0; tlast[d] = 0; tuser[d] = '0;
            fready[d] = 1'b1; crv[d] = 0; crvc[d] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // T1 reset state
        for (int v = 0; v < 12; v++) chk($sformatf("t1_cred%0d", v), cred(0, v), 12);
        chk("t1_flit_valid", fvalid[0], 0);
        chk("t1_tready", tready[0], 0);
        chk("t1_err", err[0], 0);
        chk("t1_busy", busy[0], 0);
        chk("t1_flit_data", fdata[0], 0);

        // T2 3-beat packet to VC0
        send_pkt(0, 4'd5, 3, 24'hA0, 4'd0);
        wait_idle(0);
        chk("t2_cred0", cred(0, 0), 8);
        chk("t2_cred1", cred(0, 1), 12);

        // T3 max-credit allocation with lowest-index tie break
        reset_duts();
        for (int i = 0; i < 12; i++) send_pkt(0, 4'(i), 2, 24'(32'h100 + i * 16), 4'(i));
        send_pkt(0, 4'h9, 5, 24'h300, 4'd0);
        for (int i = 1; i < 4; i++) send_pkt(0, 4'(i), 2, 24'(32'h340 + i * 16), 4'(i));
        send_pkt(0, 4'hC, 1, 24'h3F0, 4'd4);
        wait_idle(0);
        for (int v = 0; v < 12; v++)
            chk($sformatf("t3_cred%0d", v), cred(0, v),
                (v == 0) ? 3 : (v < 4) ? 6 : (v == 4) ? 7 : 9);

        // T4 credit exhausted mid-packet on the locked VC
        reset_duts();
        begin
            int a0;
            a0   = acc0;
            done = 0;
            fork
                begin
                    send_pkt(0, 4'h3, 13, 24'h400, 4'd0);
                    done = 1;
                end
            join_none
            ok = 0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(negedge clk);
                if (cred(0, 0) == 0) ok = 1;
            end
            if (!ok) timeout("t4_drain");
            chk("t4_beats_before", 64'(acc0 - a0), 11);
            repeat (2) @(negedge clk);
            chk("t4_tready_stall", tready[0], 0);
            chk("t4_no_flit", fvalid[0], 0);
            @(posedge clk); #1 crv[0] = 1'b1; crvc[0] = 4'd0;
            @(posedge clk); #1 crv[0] = 1'b0;
            repeat (4) @(negedge clk);
            chk("t4_one_beat", 64'(acc0 - a0), 12);
            chk("t4_tready_stall2", tready[0], 0);
            @(posedge clk); #1 crv[0] = 1'b1; crvc[0] = 4'd0;
            @(posedge clk); #1 crv[0] = 1'b0;
            ok = 0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                if (done) ok = 1;
            end
            if (!ok) timeout("t4_finish");
            wait_idle(0);
            chk("t4_all_beats", 64'(acc0 - a0), 13);
            chk("t4_cred0", cred(0, 0), 0);
        end

        // T5 simultaneous load and return, then overflow
        reset_duts();
        send_pkt(0, 4'd1, 1, 24'h500, 4'd0);
        send_pkt(0, 4'd2, 1, 24'h510, 4'd1);
        done = 0;
        fork
            begin
                send_pkt(0, 4'd7, 3, 24'h520, 4'd2);
                done = 1;
            end
        join_none
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (tvalid[0] && tready[0]) ok = 1;
        end
        if (!ok) timeout("t5_first_beat");
        chk("t5_cred2_before", cred(0, 2), 11);
        crv[0] = 1'b1; crvc[0] = 4'd2;
        @(posedge clk); #1 crv[0] = 1'b0;
        @(negedge clk);
        chk("t5_cred2_same_cycle", cred(0, 2), 11);
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (done) ok = 1;
        end
        if (!ok) timeout("t5_finish");
        wait_idle(0);
        chk("t5_cred2_end", cred(0, 2), 9);
        chk("t5_err_before", err[0], 0);
        @(posedge clk); #1 crv[0] = 1'b1; crvc[0] = 4'd5;
        @(posedge clk); #1 crv[0] = 1'b0;
        @(negedge clk);
        chk("t5_cred5_sat", cred(0, 5), 12);
        chk("t5_err_set", err[0], 1);

        // T6 round-robin allocation, then reset mid-packet
        reset_duts();
        for (int i = 0; i < 4; i++) send_pkt(1, 4'(i), 1, 24'(32'h600 + i), 4'(i));
        wait_idle(1);
        push(1, 4'd4, {2'b11, 20'd0, 4'h9});
        tuser[1] = 4'h9; tdata[1] = 24'h650; tlast[1] = 1'b1; tvalid[1] = 1'b1;
        ok = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            if (fvalid[1]) ok = 1;
        end
        if (!ok) timeout("t6_hdr");
        @(posedge clk);
        #1 rst = 1'b1;
        tvalid[1] = 1'b0; tlast[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_busy", busy[1], 0);
        chk("t6_flit_valid", fvalid[1], 0);
        chk("t6_tready", tready[1], 0);
        for (int v = 0; v < 12; v++) chk($sformatf("t6_cred%0d", v), cred(1, v), 12);
        send_pkt(1, 4'hE, 1, 24'h700, 4'd0);
        wait_idle(1);

        chk("q0_empty", 64'(q0.size()), 0);
        chk("q1_empty", 64'(q1.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
